// File: rtl/issue_scoreboard_pkg.sv
// Shared encodings for the issue scoreboard: functional-unit issue classes.
package issue_scoreboard_pkg;

  typedef enum logic [1:0] {
    ISSUE_ALU  = 2'd0,
    ISSUE_LOAD = 2'd1,
    ISSUE_MUL  = 2'd2,
    ISSUE_DIV  = 2'd3
  } issue_class_e;

endpackage

// File: rtl/issue_scoreboard_pend_slot.sv
// One scoreboard entry: pending-write counter plus a tag recording whether a load set it.
module pend_slot #(
  parameter int CW = 3
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          advance_i,
  input  logic          set_i,
  input  logic [CW-1:0] setVal_i,
  input  logic          setLoad_i,
  input  logic          divClear_i,
  output logic          busy_o,
  output logic          loadTag_o
);

  localparam logic [CW-1:0] DIV_MARK = '1;

  logic [CW-1:0] pend_q, pend_d;
  logic          loadTag_q, loadTag_d;

  // The divider mark never counts down; only the writeback pulse releases it.
  // A fresh issue overrides both the countdown and any writeback clear.
  always_comb begin
    pend_d    = pend_q;
    loadTag_d = loadTag_q;
    if (advance_i && (pend_q != '0) && (pend_q != DIV_MARK)) begin
      pend_d = pend_q - CW'(1);
    end
    if (divClear_i) begin
      pend_d = '0;
    end
    if (set_i) begin
      pend_d    = setVal_i;
      loadTag_d = setLoad_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pend_q    <= '0;
      loadTag_q <= 1'b0;
    end else begin
      pend_q    <= pend_d;
      loadTag_q <= loadTag_d;
    end
  end

  assign busy_o    = (pend_q != '0);
  assign loadTag_o = loadTag_q;

endmodule

// File: rtl/issue_scoreboard.sv
// Per-register pending-write scoreboard deciding issue/hold between decode and execute.
module issue_scoreboard
  import issue_scoreboard_pkg::*;
#(
  parameter int NREG         = 32,
  parameter int RW           = $clog2(NREG),
  parameter int CW           = 3,
  parameter int LAT_LOAD     = 1,
  parameter int LAT_MUL      = 2,
  parameter int CTRL_PENALTY = 2
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            run_i,
  input  logic            stall_i,
  input  logic            id_valid_i,
  input  logic [RW-1:0]   id_rs1_i,
  input  logic [RW-1:0]   id_rs2_i,
  input  logic            id_use_rs1_i,
  input  logic            id_use_rs2_i,
  input  logic [RW-1:0]   id_rd_i,
  input  logic            id_reg_we_i,
  input  logic [1:0]      id_class_i,
  input  logic            id_ctrl_i,
  input  logic            div_ready_i,
  output logic            issue_o,
  output logic            hold_o,
  output logic            mem_hazard_o,
  output logic            div_hazard_o,
  output logic [NREG-1:0] busy_mask_o
);

  logic [NREG-1:0] busyVec;
  logic [NREG-1:0] loadTagVec;
  logic [CW-1:0]   ctrlCnt_q, ctrlCnt_d;
  logic            divBusy_q, divBusy_d;
  logic [RW-1:0]   divRd_q, divRd_d;

  logic advance;
  logic raw1, raw2, waw, structHaz, ctlHaz, hazard;
  logic divDone, issueDiv, writeRd;
  logic [CW-1:0] setVal;

  assign advance = run_i && !stall_i;

  // Hazards look only at registered state, so a slot freed this cycle still blocks.
  assign raw1      = id_use_rs1_i && (id_rs1_i != '0) && busyVec[id_rs1_i];
  assign raw2      = id_use_rs2_i && (id_rs2_i != '0) && busyVec[id_rs2_i];
  assign waw       = id_reg_we_i  && (id_rd_i  != '0) && busyVec[id_rd_i];
  assign structHaz = (id_class_i == ISSUE_DIV) && divBusy_q;
  assign ctlHaz    = (ctrlCnt_q != '0);
  assign hazard    = raw1 || raw2 || waw || structHaz || ctlHaz;

  assign issue_o      = id_valid_i && advance && !hazard;
  assign hold_o       = id_valid_i && (hazard || !advance);
  assign mem_hazard_o = hold_o && ((raw1 && loadTagVec[id_rs1_i]) ||
                                   (raw2 && loadTagVec[id_rs2_i]) ||
                                   (waw  && loadTagVec[id_rd_i]));

  assign divDone  = div_ready_i && divBusy_q;
  assign issueDiv = issue_o && (id_class_i == ISSUE_DIV);
  assign writeRd  = issue_o && id_reg_we_i && (id_rd_i != '0);

  always_comb begin
    setVal = '0;
    case (issue_class_e'(id_class_i))
      ISSUE_ALU:  setVal = '0;
      ISSUE_LOAD: setVal = CW'(LAT_LOAD);
      ISSUE_MUL:  setVal = CW'(LAT_MUL);
      ISSUE_DIV:  setVal = '1;
      default:    setVal = '0;
    endcase
  end

  assign busyVec[0]    = 1'b0;
  assign loadTagVec[0] = 1'b0;

  for (genvar r = 1; r < NREG; r++) begin : gSlot
    pend_slot #(
      .CW(CW)
    ) uSlot (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .advance_i  (advance),
      .set_i      (writeRd && (id_rd_i == RW'(r))),
      .setVal_i   (setVal),
      .setLoad_i  (id_class_i == ISSUE_LOAD),
      .divClear_i (divDone && (divRd_q == RW'(r))),
      .busy_o     (busyVec[r]),
      .loadTag_o  (loadTagVec[r])
    );
  end

  // Writeback is honoured even while frozen; a later DIV issue wins over the release.
  always_comb begin
    ctrlCnt_d = ctrlCnt_q;
    divBusy_d = divBusy_q;
    divRd_d   = divRd_q;
    if (advance && (ctrlCnt_q != '0)) begin
      ctrlCnt_d = ctrlCnt_q - CW'(1);
    end
    if (issue_o && id_ctrl_i) begin
      ctrlCnt_d = CW'(CTRL_PENALTY);
    end
    if (divDone) begin
      divBusy_d = 1'b0;
    end
    if (issueDiv) begin
      divBusy_d = 1'b1;
      divRd_d   = id_rd_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ctrlCnt_q <= '0;
      divBusy_q <= 1'b0;
      divRd_q   <= '0;
    end else begin
      ctrlCnt_q <= ctrlCnt_d;
      divBusy_q <= divBusy_d;
      divRd_q   <= divRd_d;
    end
  end

  assign div_hazard_o = divBusy_q;
  assign busy_mask_o  = busyVec;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed bench for issue_scoreboard: load/mul/div/control hazards, stall, x0 and reset.
module tb_issue_scoreboard;

  logic        clk = 1'b0;
  logic        reset, run, stall;
  logic        idValid, useRs1, useRs2, regWe, ctrl, divReady;
  logic [4:0]  rs1, rs2, rd;
  logic [1:0]  cls;
  logic        issue, hold, memHazard, divHazard;
  logic [31:0] busyMask;

  int testsRun = 0;
  int failCount = 0;

  always #5 clk = ~clk;

  issue_scoreboard dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .run_i        (run),
    .stall_i      (stall),
    .id_valid_i   (idValid),
    .id_rs1_i     (rs1),
    .id_rs2_i     (rs2),
    .id_use_rs1_i (useRs1),
    .id_use_rs2_i (useRs2),
    .id_rd_i      (rd),
    .id_reg_we_i  (regWe),
    .id_class_i   (cls),
    .id_ctrl_i    (ctrl),
    .div_ready_i  (divReady),
    .issue_o      (issue),
    .hold_o       (hold),
    .mem_hazard_o (memHazard),
    .div_hazard_o (divHazard),
    .busy_mask_o  (busyMask)
  );

  // Drives one decoded instruction; v=0 leaves the decode slot empty.
  task automatic applyStimulus(input logic v, input logic [1:0] c, input logic [4:0] d,
                               input logic we, input logic [4:0] s1, input logic u1,
                               input logic [4:0] s2, input logic u2, input logic isCtrl);
    idValid = v;  cls = c;   rd = d;   regWe = we;
    rs1 = s1;     useRs1 = u1; rs2 = s2; useRs2 = u2; ctrl = isCtrl;
  endtask

  // Samples 1ns after the falling edge and compares all outputs.
  task automatic checkOutput(input string tag, input logic eIssue, input logic eHold,
                             input logic eMem, input logic eDiv, input logic [31:0] eMask);
    #1;
    testsRun++;
    assert (issue === eIssue) else begin
      failCount++;
      $error("[TB] FAIL %s issue got %0b expected %0b", tag, issue, eIssue);
    end
    testsRun++;
    assert (hold === eHold) else begin
      failCount++;
      $error("[TB] FAIL %s hold got %0b expected %0b", tag, hold, eHold);
    end
    testsRun++;
    assert (memHazard === eMem) else begin
      failCount++;
      $error("[TB] FAIL %s mem_hazard got %0b expected %0b", tag, memHazard, eMem);
    end
    testsRun++;
    assert (divHazard === eDiv) else begin
      failCount++;
      $error("[TB] FAIL %s div_hazard got %0b expected %0b", tag, divHazard, eDiv);
    end
    testsRun++;
    assert (busyMask === eMask) else begin
      failCount++;
      $error("[TB] FAIL %s busy_mask got %h expected %h", tag, busyMask, eMask);
    end
  endtask

  task automatic nextCycle();
    @(negedge clk);
  endtask

  task automatic idle();
    applyStimulus(1'b0, 2'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; run = 1'b1; stall = 1'b0; divReady = 1'b0;
    idle();
    repeat (2) nextCycle();
    reset = 1'b0;
    checkOutput("reset", 0, 0, 0, 0, 32'h0);
    nextCycle();

    // LOAD x5 then dependent ADD: one hold cycle flagged as memory hazard
    applyStimulus(1, 2'd1, 5'd5, 1, 5'd0, 0, 5'd0, 0, 0);
    checkOutput("load_issue", 1, 0, 0, 0, 32'h0);
    nextCycle();
    applyStimulus(1, 2'd0, 5'd10, 1, 5'd5, 1, 5'd0, 0, 0);
    checkOutput("load_use_hold", 0, 1, 1, 0, 32'h20);
    nextCycle();
    checkOutput("load_use_issue", 1, 0, 0, 0, 32'h0);
    nextCycle();

    // LOAD x5 then independent ADD on x6 issues at once
    applyStimulus(1, 2'd1, 5'd5, 1, 5'd0, 0, 5'd0, 0, 0);
    checkOutput("load2_issue", 1, 0, 0, 0, 32'h0);
    nextCycle();
    applyStimulus(1, 2'd0, 5'd11, 1, 5'd6, 1, 5'd0, 0, 0);
    checkOutput("indep_add", 1, 0, 0, 0, 32'h20);
    nextCycle();

    // LOAD x8 then ALU writing x8: WAW against a load
    applyStimulus(1, 2'd1, 5'd8, 1, 5'd0, 0, 5'd0, 0, 0);
    checkOutput("load3_issue", 1, 0, 0, 0, 32'h0);
    nextCycle();
    applyStimulus(1, 2'd0, 5'd8, 1, 5'd0, 0, 5'd0, 0, 0);
    checkOutput("waw_load_hold", 0, 1, 1, 0, 32'h100);
    nextCycle();
    checkOutput("waw_load_issue", 1, 0, 0, 0, 32'h0);
    nextCycle();

    // MUL x7 then ADD reading rs2=x7: two hold cycles
    applyStimulus(1, 2'd2, 5'd7, 1, 5'd0, 0, 5'd0, 0, 0);
    checkOutput("mul_issue", 1, 0, 0, 0, 32'h0);
    nextCycle();
    applyStimulus(1, 2'd0, 5'd12, 1, 5'd1, 1, 5'd7, 1, 0);
    checkOutput("mul_hold1", 0, 1, 0, 0, 32'h80);
    nextCycle();
    checkOutput("mul_hold2", 0, 1, 0, 0, 32'h80);
    nextCycle();
    checkOutput("mul_issue_dep", 1, 0, 0, 0, 32'h0);
    nextCycle();

    // DIV x3 then DIV x4: structural hold until the writeback pulse
    applyStimulus(1, 2'd3, 5'd3, 1, 5'd0, 0, 5'd0, 0, 0);
    checkOutput("div1_issue", 1, 0, 0, 0, 32'h0);
    nextCycle();
    applyStimulus(1, 2'd3, 5'd4, 1, 5'd0, 0, 5'd0, 0, 0);
    for (int i = 0; i < 9; i++) begin
      checkOutput("div_struct_hold", 0, 1, 0, 1, 32'h8);
      nextCycle();
    end
    divReady = 1'b1;
    checkOutput("div_ready_cycle", 0, 1, 0, 1, 32'h8);
    nextCycle();
    divReady = 1'b0;
    checkOutput("div2_issue", 1, 0, 0, 0, 32'h0);
    nextCycle();
    idle();
    divReady = 1'b1;
    checkOutput("div2_pending", 0, 0, 0, 1, 32'h10);
    nextCycle();
    divReady = 1'b0;
    checkOutput("div2_done", 0, 0, 0, 0, 32'h0);
    nextCycle();

    // Branch: exactly two hold cycles on an independent ADD
    applyStimulus(1, 2'd0, 5'd0, 0, 5'd1, 1, 5'd2, 1, 1);
    checkOutput("beq_issue", 1, 0, 0, 0, 32'h0);
    nextCycle();
    applyStimulus(1, 2'd0, 5'd2, 1, 5'd1, 1, 5'd0, 0, 0);
    checkOutput("ctl_hold1", 0, 1, 0, 0, 32'h0);
    nextCycle();
    checkOutput("ctl_hold2", 0, 1, 0, 0, 32'h0);
    nextCycle();
    checkOutput("ctl_release", 1, 0, 0, 0, 32'h0);
    nextCycle();

    // Branch with three stall cycles inside the penalty window
    applyStimulus(1, 2'd0, 5'd0, 0, 5'd1, 1, 5'd2, 1, 1);
    checkOutput("beq2_issue", 1, 0, 0, 0, 32'h0);
    nextCycle();
    applyStimulus(1, 2'd0, 5'd2, 1, 5'd1, 1, 5'd0, 0, 0);
    checkOutput("ctl2_hold1", 0, 1, 0, 0, 32'h0);
    nextCycle();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checkOutput("ctl2_stalled", 0, 1, 0, 0, 32'h0);
      nextCycle();
    end
    stall = 1'b0;
    checkOutput("ctl2_hold2", 0, 1, 0, 0, 32'h0);
    nextCycle();
    checkOutput("ctl2_release", 1, 0, 0, 0, 32'h0);
    nextCycle();

    // run low holds even an independent instruction
    run = 1'b0;
    applyStimulus(1, 2'd0, 5'd13, 1, 5'd14, 1, 5'd0, 0, 0);
    checkOutput("run_low", 0, 1, 0, 0, 32'h0);
    nextCycle();
    run = 1'b1;

    // Writes to x0 are never tracked
    applyStimulus(1, 2'd1, 5'd0, 1, 5'd0, 0, 5'd0, 0, 0);
    checkOutput("load_x0", 1, 0, 0, 0, 32'h0);
    nextCycle();
    applyStimulus(1, 2'd0, 5'd0, 1, 5'd0, 1, 5'd0, 1, 0);
    checkOutput("read_x0", 1, 0, 0, 0, 32'h0);
    nextCycle();

    // Reset while a divide to x9 is pending; stray writeback afterwards ignored
    applyStimulus(1, 2'd3, 5'd9, 1, 5'd0, 0, 5'd0, 0, 0);
    checkOutput("div9_issue", 1, 0, 0, 0, 32'h0);
    nextCycle();
    idle();
    checkOutput("div9_pending", 0, 0, 0, 1, 32'h200);
    reset = 1'b1;
    nextCycle();
    reset = 1'b0;
    checkOutput("after_reset", 0, 0, 0, 0, 32'h0);
    divReady = 1'b1;
    nextCycle();
    divReady = 1'b0;
    checkOutput("stray_div_ready", 0, 0, 0, 0, 32'h0);
    applyStimulus(1, 2'd3, 5'd9, 1, 5'd0, 0, 5'd0, 0, 0);
    checkOutput("div_after_reset", 1, 0, 0, 0, 32'h0);
    nextCycle();
    idle();

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule

// File: doc/issue_scoreboard.md
Name: issue_scoreboard

Overview:
Parametrised hazard/issue controller sitting between instruction decode and the execute pipeline register. It replaces the fixed "stall N cycles after any load/branch/div" sequencing with a per-register pending-write scoreboard. Independent instructions therefore issue back-to-back, and only true RAW/WAW dependencies, structural (single divider) conflicts and control penalties stall. Latencies per functional-unit class are parameters.

Parameters:
NREG, 32, number of architectural registers; register 0 is hardwired zero and never tracked
RW, $clog2(NREG), register index width
CW, 3, pending-counter width; all-ones value reserved as "divider pending" mark
LAT_LOAD, 1, cycles a load result is unavailable after issue (must be < 2**CW-1)
LAT_MUL, 2, cycles a multiply result is unavailable after issue (must be < 2**CW-1)
CTRL_PENALTY, 2, hold cycles after issuing a branch/jal/jalr (must be < 2**CW)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
run  in  1  core running; no issue and no counter progress when 0
stall  in  1  downstream back-pressure; freezes issue and all counters
id_valid  in  1  decoded instruction present
id_rs1  in  RW  source 1 index
id_rs2  in  RW  source 2 index
id_use_rs1  in  1  instruction reads rs1
id_use_rs2  in  1  instruction reads rs2
id_rd  in  RW  destination index
id_reg_we  in  1  instruction writes rd
id_class  in  2  0=ALU, 1=LOAD, 2=MUL, 3=DIV
id_ctrl  in  1  branch/jal/jalr
div_ready  in  1  one-cycle pulse: divider result written back
issue  out  1  instruction accepted this cycle (combinational)
hold  out  1  upstream must keep the current instruction (combinational)
mem_hazard  out  1  hold caused by a pending load destination
div_hazard  out  1  divider busy (registered)
busy_mask  out  NREG  bit r set when pend[r] != 0 (registered)

Behaviour:
- Clock is clk. Reset is synchronous and active-high on reset. One clock domain.
- State:
  - pend[1..NREG-1], CW bits each.
  - ctrl_cnt, CW bits.
  - div_busy and div_rd (RW bits).
- Reset: all pend=0, ctrl_cnt=0, div_busy=0, div_rd=0. Outputs after reset: busy_mask=0, div_hazard=0, issue=0, hold=0 (with id_valid=0), mem_hazard=0.
- advance = run && !stall.
- Hazard terms, evaluated on registered state only; same-cycle clears are never bypassed (one cycle conservative):
  - raw1 = id_use_rs1 && rs1!=0 && pend[rs1]!=0
  - raw2 = the same check for rs2
  - waw = id_reg_we && rd!=0 && pend[rd]!=0
  - struct = id_class==DIV && div_busy
  - ctl = ctrl_cnt!=0
- hazard = raw1|raw2|waw|struct|ctl.
- Outputs:
  - issue = id_valid && advance && !hazard.
  - hold = id_valid && (hazard || !advance).
  - mem_hazard = hold && a RAW/WAW-matched register was set by a LOAD. Track this with a 1-bit class tag per register.
- On each advance cycle:
  - Every pend[r] with 0 < pend[r] < all-ones decrements by 1.
  - ctrl_cnt decrements if nonzero.
- On issue with id_reg_we && rd!=0:
  - pend[rd] <= 0 for ALU (forwarding path), LAT_LOAD for LOAD, LAT_MUL for MUL, all-ones for DIV.
  - A new value overrides the same-cycle decrement.
- On issue of DIV: div_busy<=1 and div_rd<=rd. DIV with rd=0 still sets div_busy.
- On issue with id_ctrl: ctrl_cnt <= CTRL_PENALTY.
- div_ready pulse clears div_busy and sets pend[div_rd]=0 (when div_rd!=0) regardless of stall/run. div_ready while !div_busy is ignored.
- Simultaneous div_ready and an issue targeting div_rd cannot occur, because waw blocks it this cycle.
- run=0 or stall=1 freezes all counters. div_ready is still honoured.
- Reset mid-operation (divider pending, ctrl hold) clears all state in the next cycle. A later stray div_ready is ignored.
- x0 is never marked busy; busy_mask[0] is always 0.

Decomposition:
- Issue-class encodings (ISSUE_ALU/LOAD/MUL/DIV) and the DIV pending mark go in core.svh beside the existing ALU/MUL/DIV op constants.
- Per-register logic (counter, decrement, load-tag, set/clear priority) goes in one sub-module, pend_slot, instantiated NREG-1 times via generate.
- Hazard and issue logic stay in the top level.

Test Plan:
- LOAD rd=5 issued, next cycle ADD rs1=5 -> hold=1, mem_hazard=1 for 1 cycle, issue on the following cycle. An ADD rs1=6 instead issues immediately.
- MUL rd=7, then ADD rs2=7 -> hold 2 cycles, busy_mask[7] sequence 1,1,0, issue on the 3rd cycle.
- DIV rd=3, then DIV rd=4 -> hold (struct) until div_ready. div_ready pulse 10 cycles later -> busy_mask[3]=0, div_hazard=0, second DIV issues the cycle after the pulse.
- BEQ issued -> hold=1 exactly 2 cycles on an independent following ADD. With stall asserted for 3 cycles in between, the hold extends by 3.
- Instruction writing rd=0 as LOAD, then reading x0 -> no hold; busy_mask stays 0.
- Reset asserted while DIV rd=9 pending -> busy_mask=0, div_hazard=0 next cycle. A later div_ready causes no change.
